// File: rtl/demux_dispatch_ctrl.sv
// Single-entry dispatch controller driving a 1:8 demux.
// Round-robin or directed targeting with drop accounting.
module demux_dispatch_ctrl #(
   parameter int DW      = 8,
   parameter int DROP_CW = 8
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               mode,
   input  logic [7:0]         ch_en,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [DW-1:0]      in_data,
   input  logic [2:0]         in_dst,
   output logic [2:0]         demux_sel,
   output logic               demux_din,
   output logic [DW-1:0]      out_data,
   input  logic [7:0]         out_ready,
   output logic [15:0]        xfer_cnt,
   output logic [DROP_CW-1:0] drop_cnt,
   output logic               err_drop
);

   typedef enum logic {IDLE, SEND} state_t;

   state_t     state;
   logic [2:0] rr_ptr;
   logic [2:0] rr_tgt;
   logic [2:0] rr_idx;
   logic       rr_hit;
   logic [2:0] tgt;
   logic       stall;
   logic       fire;
   logic       accept;
   logic       drop;

   // First enabled channel after rr_ptr, wrapping mod 8.
   always_comb begin
      rr_tgt = rr_ptr;
      rr_idx = '0;
      rr_hit = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         rr_idx = rr_ptr + 3'(i);
         if (!rr_hit && ch_en[rr_idx]) begin
            rr_tgt = rr_idx;
            rr_hit = 1'b1;
         end
      end
   end

   always_comb begin
      stall    = ~mode & ~|ch_en;
      fire     = (state == SEND) & out_ready[demux_sel];
      in_ready = ~stall & ((state == IDLE) | out_ready[demux_sel]);
      accept   = in_valid & in_ready;
      drop     = mode & ~ch_en[in_dst];
      tgt      = mode ? in_dst : rr_tgt;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state     <= IDLE;
         rr_ptr    <= 3'd7;
         demux_sel <= '0;
         demux_din <= 1'b0;
         out_data  <= '0;
         xfer_cnt  <= '0;
         drop_cnt  <= '0;
         err_drop  <= 1'b0;
      end else begin
         err_drop <= accept & drop;
         if (fire)
            xfer_cnt <= xfer_cnt + 16'd1;
         if (accept && drop && !(&drop_cnt))
            drop_cnt <= drop_cnt + DROP_CW'(1);
         if (accept && !mode)
            rr_ptr <= rr_tgt;
         // A new beat overrides the drain so throughput stays at 1/cycle.
         if (accept && !drop) begin
            state     <= SEND;
            demux_sel <= tgt;
            out_data  <= in_data;
            demux_din <= 1'b1;
         end else if (fire) begin
            state     <= IDLE;
            demux_din <= 1'b0;
         end
      end
   end

endmodule
